// File: rtl/seq_sched_pkg.sv
// rtl/seq_sched_pkg.sv - shared types and defaults for the pair scheduler
// Purpose: FSM state encoding, default channel count / gap width, gap type.
// Ports: none (package).
package seq_sched_pkg;

   localparam int NCH_DEF  = 4;
   localparam int GAPW_DEF = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef logic [GAPW_DEF-1:0] gap_t;

endpackage

// File: rtl/seq_pair_chan.sv
// rtl/seq_pair_chan.sv - one scheduler channel: captures enable/gap, emits x then y
// Purpose: on launch, captures the channel enable and loads the gap counter;
//          x pulses in the following cycle, y pulses gap cycles after x.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   launch      batch accepted this edge
//   enable      channel enable, sampled with launch
//   gap         x->y distance, sampled with launch
//   x, y        registered one-cycle pulses
//   pending     y still outstanding (counter non-zero on an enabled channel)
module seq_pair_chan
   import seq_sched_pkg::*;
#(
   parameter int GAPW = GAPW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            launch,
   input  logic            enable,
   input  logic [GAPW-1:0] gap,
   output logic            x,
   output logic            y,
   output logic            pending
);

   logic            en_q;
   logic [GAPW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q <= 1'b0;
         cnt  <= '0;
         x    <= 1'b0;
         y    <= 1'b0;
      end else if (launch) begin
         en_q <= enable;
         cnt  <= gap;
         x    <= enable;
         // zero gap: y coincides with x
         y    <= enable && (gap == '0);
      end else begin
         x <= 1'b0;
         if (cnt != '0) begin
            // counter reaching zero on this edge puts y in the next cycle
            cnt <= cnt - GAPW'(1);
            y   <= en_q && (cnt == GAPW'(1));
         end else begin
            y <= 1'b0;
         end
      end
   end

   // a disabled channel may still count down its loaded gap; it never holds the batch open
   assign pending = en_q && (cnt != '0);

endmodule

// File: rtl/seq_pair_sched.sv
// rtl/seq_pair_sched.sv - multi-channel x/y pulse-pair scheduler (top)
// Purpose: a start pulse launches per-channel x/y pairs (x one cycle after
//          start, y gap[i] cycles after x); busy covers the batch, done pulses at its end.
// Optional: define SEQ_PAIR_SCHED_SVA_EN to compile in embedded assertions.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       launch request (ignored unless idle and some channel enabled)
//   ch_en       per-channel enable, sampled with accepted start
//   gap         per-channel gap, channel i at [i*GAPW +: GAPW]
//   x, y        per-channel pulse pair
//   busy        batch in progress (RUN and DONE)
//   done        one-cycle batch-complete pulse
module seq_pair_sched
   import seq_sched_pkg::*;
#(
   parameter int NCH  = NCH_DEF,
   parameter int GAPW = GAPW_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [NCH-1:0]      ch_en,
   input  logic [NCH*GAPW-1:0] gap,
   output logic [NCH-1:0]      x,
   output logic [NCH-1:0]      y,
   output logic                busy,
   output logic                done
);

   state_e         state, state_n;
   logic           launch;
   logic [NCH-1:0] pending;
   logic           any_pending;

   assign launch      = (state == IDLE) && start && (|ch_en);
   assign any_pending = |pending;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      seq_pair_chan #(.GAPW(GAPW)) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .launch  (launch),
         .enable  (ch_en[i]),
         .gap     (gap[i*GAPW +: GAPW]),
         .x       (x[i]),
         .y       (y[i]),
         .pending (pending[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         // busy/done registered from the next state so they align with it
         busy  <= (state_n != IDLE);
         done  <= (state_n == DONE);
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (launch) state_n = RUN;
         // counters are all zero once the last y is on the outputs
         RUN:     if (!any_pending) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

`ifdef SEQ_PAIR_SCHED_SVA_EN
   logic [NCH-1:0][GAPW-1:0] gap_q;
   logic [NCH-1:0][GAPW-1:0] elapsed;
   logic [NCH-1:0]           armed;

   // shadow tracker: cycles elapsed since each channel's x
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_q   <= '0;
         elapsed <= '0;
         armed   <= '0;
      end else begin
         if (launch) gap_q <= gap;
         for (int i = 0; i < NCH; i++) begin
            if (y[i]) begin
               armed[i] <= 1'b0;
            end else if (x[i]) begin
               armed[i]   <= 1'b1;
               elapsed[i] <= GAPW'(1);
            end else if (armed[i]) begin
               elapsed[i] <= elapsed[i] + GAPW'(1);
            end
         end
      end
   end

   a_launch: assert property (@(posedge clk) disable iff (!rst_n)
      start && !busy && (|ch_en) |=> (|x))
      else $error("accepted start produced no x");

   a_done_busy: assert property (@(posedge clk) disable iff (!rst_n)
      done |-> busy)
      else $error("done without busy");

   // a start while busy launches nothing
   a_busy_start: assert property (@(posedge clk) disable iff (!rst_n)
      start && busy |=> (x == '0))
      else $error("start during batch changed x");

   for (genvar i = 0; i < NCH; i++) begin : g_sva
      a_pair: assert property (@(posedge clk) disable iff (!rst_n)
         (x[i] && gap_q[i] == '0) || (armed[i] && !x[i] && elapsed[i] == gap_q[i]) |-> y[i])
         else $error("y missing after x on channel %0d", i);

      a_orphan: assert property (@(posedge clk) disable iff (!rst_n)
         y[i] |-> (x[i] || armed[i]))
         else $error("y without prior x on channel %0d", i);
   end
`endif

endmodule

// File: tb/tb_seq_pair_sched.sv
// tb/tb_seq_pair_sched.sv - table-driven bench for seq_pair_sched
module tb_seq_pair_sched;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  ch_en;
   logic [11:0] gap;
   logic [3:0]  x;
   logic [3:0]  y;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        start;
      logic [3:0]  ch_en;
      logic [11:0] gap;
      logic [3:0]  ex;
      logic [3:0]  ey;
      logic        ebusy;
      logic        edone;
   } vec_t;

   vec_t tbl[$];

   seq_pair_sched #(.NCH(4), .GAPW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .ch_en (ch_en),
      .gap   (gap),
      .x     (x),
      .y     (y),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic s, input logic [3:0] en, input logic [11:0] g,
                      input logic [3:0] ex, input logic [3:0] ey, input logic eb, input logic ed);
      vec_t v;
      v.start = s; v.ch_en = en; v.gap = g;
      v.ex = ex; v.ey = ey; v.ebusy = eb; v.edone = ed;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int idx,
                          input logic [3:0] ex, input logic [3:0] ey, input logic eb, input logic ed);
      n_vec++;
      chk({tag, ".x"}, idx, x, ex);
      chk({tag, ".y"}, idx, y, ey);
      chk({tag, ".busy"}, idx, {3'b000, busy}, {3'b000, eb});
      chk({tag, ".done"}, idx, {3'b000, done}, {3'b000, ed});
   endtask

   task automatic step(input logic s, input logic [3:0] en, input logic [11:0] g);
      @(negedge clk);
      start = s; ch_en = en; gap = g;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ch_en = '0; gap = '0;

      // gaps ch0=1 ch1=2 ch2=3 ch3=0 on channels 0..2
      add(1, 4'b0111, 12'h0D1, 4'b0111, 4'b0000, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0001, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0010, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0100, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 1, 1);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0);
      // start with no channel enabled is ignored
      add(1, 4'b0000, 12'hFFF, 4'b0000, 4'b0000, 0, 0);
      for (int i = 0; i < 9; i++) add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0);
      // zero gap: x and y together; starts in RUN and DONE are dropped, not queued
      add(1, 4'b0001, 12'h000, 4'b0001, 4'b0001, 1, 0);
      add(1, 4'b0001, 12'h000, 4'b0000, 4'b0000, 1, 1);
      add(1, 4'b0001, 12'h000, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0);
      // gap 4, restart two edges later with different enables/gaps: no effect
      add(1, 4'b0001, 12'h004, 4'b0001, 4'b0000, 1, 0);
      add(0, 4'b0001, 12'h004, 4'b0000, 4'b0000, 1, 0);
      add(1, 4'b1111, 12'h000, 4'b0000, 4'b0000, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0001, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 1, 1);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0);
      // gap 1, back-to-back batches: second start in first idle cycle after done
      add(1, 4'b0001, 12'h001, 4'b0001, 4'b0000, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0001, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 1, 1);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0);
      add(1, 4'b0001, 12'h001, 4'b0001, 4'b0000, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0001, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 1, 1);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0);
      // max gap on channel 3 only: busy spans 2^GAPW+1 cycles
      add(1, 4'b1000, 12'hE00, 4'b1000, 4'b0000, 1, 0);
      for (int i = 0; i < 6; i++) add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b1000, 1, 0);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 1, 1);
      add(0, 4'b0000, 12'h000, 4'b0000, 4'b0000, 0, 0);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].start, tbl[i].ch_en, tbl[i].gap);
         chk_all("vec", i, tbl[i].ex, tbl[i].ey, tbl[i].ebusy, tbl[i].edone);
      end

      // asynchronous reset mid-batch (gap 7), then a clean gap-2 batch
      step(1, 4'b0001, 12'h007);
      chk_all("rst_launch", 0, 4'b0001, 4'b0000, 1'b1, 1'b0);
      step(0, 4'b0000, 12'h000);
      step(0, 4'b0000, 12'h000);
      chk_all("rst_mid", 0, 4'b0000, 4'b0000, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("rst_async", 0, 4'b0000, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(0, 4'b0000, 12'h000);
         chk_all("rst_abandon", i, 4'b0000, 4'b0000, 1'b0, 1'b0);
      end
      step(1, 4'b0001, 12'h002);
      chk_all("post_rst", 0, 4'b0001, 4'b0000, 1'b1, 1'b0);
      step(0, 4'b0000, 12'h000);
      chk_all("post_rst", 1, 4'b0000, 4'b0000, 1'b1, 1'b0);
      step(0, 4'b0000, 12'h000);
      chk_all("post_rst", 2, 4'b0000, 4'b0001, 1'b1, 1'b0);
      step(0, 4'b0000, 12'h000);
      chk_all("post_rst", 3, 4'b0000, 4'b0000, 1'b1, 1'b1);
      step(0, 4'b0000, 12'h000);
      chk_all("post_rst", 4, 4'b0000, 4'b0000, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
